// File: rtl/reg_write_arbiter_if.sv
// Bundles the writeback requests, the issue-stage reservation, the read-port hazard
// flags and the register-file write port that reg_write_arbiter sits between.
interface reg_write_arbiter_if #(
  parameter int BitWidth = 32,
  parameter int RegCount = 32,
  parameter int ReqCount = 3
);
  localparam int AW = (RegCount > 1) ? $clog2(RegCount) : 1;

  // Handshake: a transfer on slot i happens in any cycle where reqValid[i] and
  // reqReady[i] are both 1 at the rising edge. The requester holds its valid,
  // address and data stable until it sees ready. Reservations follow the same
  // rule with reserveValid/reserveReady.
  logic [ReqCount-1:0]          reqValid;
  logic [ReqCount*AW-1:0]       reqAddr;
  logic [ReqCount*BitWidth-1:0] reqData;
  logic [ReqCount-1:0]          reqReady;
  logic                         reserveValid;
  logic [AW-1:0]                reserveAddr;
  logic                         reserveReady;
  logic [AW-1:0]                rAddr1;
  logic [AW-1:0]                rAddr2;
  logic                         hazard1;
  logic                         hazard2;
  logic                         rfWrite;
  logic [AW-1:0]                rfWAddr;
  logic [BitWidth-1:0]          rfWData;
  logic [AW:0]                  busyCount;

  modport master (
    output reqValid, reqAddr, reqData, reserveValid, reserveAddr, rAddr1, rAddr2,
    input  reqReady, reserveReady, hazard1, hazard2, rfWrite, rfWAddr, rfWData, busyCount
  );

  modport slave (
    input  reqValid, reqAddr, reqData, reserveValid, reserveAddr, rAddr1, rAddr2,
    output reqReady, reserveReady, hazard1, hazard2, rfWrite, rfWAddr, rfWData, busyCount
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a per-register
// busy scoreboard that flags read hazards on the two read ports.
module reg_write_arbiter #(
  parameter int BitWidth = 32,
  parameter int RegCount = 32,
  parameter int ReqCount = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  reg_write_arbiter_if.slave    bus
);
  localparam int AW = (RegCount > 1) ? $clog2(RegCount) : 1;
  localparam int PW = $clog2(ReqCount);

  logic [RegCount-1:0] busy;
  logic [RegCount-1:0] busyNext;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       grantIdx;
  logic [ReqCount-1:0] grant;
  logic                found;
  logic                active;
  logic [AW-1:0]       selAddr;
  logic [BitWidth-1:0] selData;
  logic                reserveAccept;
  logic                clearBusy;
  logic                rfWriteQ;
  logic [AW-1:0]       rfWAddrQ;
  logic [BitWidth-1:0] rfWDataQ;
  logic [AW:0]         busyCountQ;

  // Grants and reservations are suppressed while reset is asserted so nothing
  // in flight during a reset cycle is acknowledged to the requesters.
  assign active = enable & reset;

  always_comb begin
    int idx;
    idx      = 0;
    found    = 1'b0;
    grantIdx = '0;
    grant    = '0;
    if (active) begin
      for (int k = 0; k < ReqCount; k++) begin
        idx = (int'(ptr) + k) % ReqCount;
        if (!found && bus.reqValid[idx]) begin
          found    = 1'b1;
          grantIdx = PW'(idx);
        end
      end
    end
    if (found) grant[grantIdx] = 1'b1;
  end

  assign selAddr       = bus.reqAddr[grantIdx*AW +: AW];
  assign selData       = bus.reqData[grantIdx*BitWidth +: BitWidth];
  assign reserveAccept = bus.reserveValid & bus.reserveReady;
  assign clearBusy     = found & busy[selAddr];

  // Set is applied after clear so a same-cycle reserve of the written register wins.
  always_comb begin
    busyNext = busy;
    if (found)         busyNext[selAddr]         = 1'b0;
    if (reserveAccept) busyNext[bus.reserveAddr] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      busy       <= '0;
      ptr        <= '0;
      rfWriteQ   <= 1'b0;
      rfWAddrQ   <= '0;
      rfWDataQ   <= '0;
      busyCountQ <= '0;
    end else begin
      rfWriteQ   <= found;
      busy       <= busyNext;
      busyCountQ <= busyCountQ + (AW+1)'(reserveAccept) - (AW+1)'(clearBusy);
      if (found) begin
        rfWAddrQ <= selAddr;
        rfWDataQ <= selData;
        ptr      <= (int'(grantIdx) == ReqCount - 1) ? '0 : grantIdx + 1'b1;
      end
    end
  end

  assign bus.reqReady     = grant;
  assign bus.reserveReady = active & ~busy[bus.reserveAddr];
  assign bus.rfWrite      = rfWriteQ;
  assign bus.rfWAddr      = rfWAddrQ;
  assign bus.rfWData      = rfWDataQ;
  assign bus.busyCount    = busyCountQ;
  // The rfWrite term covers the cycle before the register file commits the data.
  assign bus.hazard1 = busy[bus.rAddr1] | (rfWriteQ & (rfWAddrQ == bus.rAddr1));
  assign bus.hazard2 = busy[bus.rAddr2] | (rfWriteQ & (rfWAddrQ == bus.rAddr2));
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: round-robin order, write-port timing,
// scoreboard reserve/clear, enable gating and mid-run reset.
module tb_reg_write_arbiter;
  localparam int BitWidth = 32;
  localparam int RegCount = 32;
  localparam int ReqCount = 3;
  localparam int AW = 5;

  logic clock;
  logic reset;
  logic enable;
  int   testCount;
  int   failCount;
  logic [AW-1:0] expQ[$];
  logic [AW-1:0] expAddr;

  reg_write_arbiter_if #(.BitWidth(BitWidth), .RegCount(RegCount), .ReqCount(ReqCount)) bus ();

  reg_write_arbiter #(.BitWidth(BitWidth), .RegCount(RegCount), .ReqCount(ReqCount)) dut (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .bus   (bus)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setReq(input int i, input logic [AW-1:0] a, input logic [BitWidth-1:0] d);
    bus.reqAddr[i*AW +: AW]             = a;
    bus.reqData[i*BitWidth +: BitWidth] = d;
  endtask

  initial begin
    testCount = 0;
    failCount = 0;

    // Reset with every input active
    reset = 1'b0;
    enable = 1'b1;
    bus.reqValid = 3'b111;
    setReq(0, 5'd1, 32'h101);
    setReq(1, 5'd2, 32'h102);
    setReq(2, 5'd3, 32'h103);
    bus.reserveValid = 1'b1;
    bus.reserveAddr = 5'd5;
    bus.rAddr1 = 5'd5;
    bus.rAddr2 = 5'd0;
    tick();
    tick();
    check("rst_rfWrite", 64'(bus.rfWrite), 64'd0);
    check("rst_busyCount", 64'(bus.busyCount), 64'd0);
    check("rst_reqReady", 64'(bus.reqReady), 64'd0);
    check("rst_reserveReady", 64'(bus.reserveReady), 64'd0);
    check("rst_hazard1", 64'(bus.hazard1), 64'd0);
    check("rst_rfWAddr", 64'(bus.rfWAddr), 64'd0);
    bus.reqValid = '0;
    bus.reserveValid = 1'b0;
    reset = 1'b1;
    tick();

    // Round-robin with all three requesters pending
    bus.reqValid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("rr_grant", 64'(bus.reqReady), 64'(3'b001 << (c % 3)));
      expQ.push_back(AW'((c % 3) + 1));
      tick();
      expAddr = expQ.pop_front();
      check("rr_rfWrite", 64'(bus.rfWrite), 64'd1);
      check("rr_rfWAddr", 64'(bus.rfWAddr), 64'(expAddr));
      check("rr_rfWData", 64'(bus.rfWData), 64'h100 + 64'(expAddr));
    end

    // Single requester
    bus.reqValid = 3'b100;
    setReq(2, 5'd7, 32'hDEADBEEF);
    #1;
    check("single_grant", 64'(bus.reqReady), 64'(3'b100));
    tick();
    check("single_rfWrite", 64'(bus.rfWrite), 64'd1);
    check("single_rfWAddr", 64'(bus.rfWAddr), 64'd7);
    check("single_rfWData", 64'(bus.rfWData), 64'hDEADBEEF);
    bus.reqValid = '0;
    #1;
    check("idle_grant", 64'(bus.reqReady), 64'd0);
    tick();
    check("idle_rfWrite", 64'(bus.rfWrite), 64'd0);
    check("idle_rfWAddr_hold", 64'(bus.rfWAddr), 64'd7);

    // Scoreboard: reserve r9, reject duplicate, write back through requester 1
    bus.reserveValid = 1'b1;
    bus.reserveAddr = 5'd9;
    #1;
    check("res9_ready", 64'(bus.reserveReady), 64'd1);
    tick();
    check("res9_busyCount", 64'(bus.busyCount), 64'd1);
    bus.rAddr1 = 5'd9;
    #1;
    check("res9_hazard1", 64'(bus.hazard1), 64'd1);
    check("res9_dup_ready", 64'(bus.reserveReady), 64'd0);
    tick();
    check("res9_dup_busyCount", 64'(bus.busyCount), 64'd1);
    bus.reserveValid = 1'b0;
    bus.reqValid = 3'b010;
    setReq(1, 5'd9, 32'h99);
    #1;
    check("wb9_grant", 64'(bus.reqReady), 64'(3'b010));
    tick();
    bus.reqValid = '0;
    #1;
    check("wb9_hazard1_rfterm", 64'(bus.hazard1), 64'd1);
    check("wb9_rfWAddr", 64'(bus.rfWAddr), 64'd9);
    tick();
    check("wb9_hazard1_clear", 64'(bus.hazard1), 64'd0);
    check("wb9_busyCount", 64'(bus.busyCount), 64'd0);

    // Same-cycle reserve and writeback of non-busy r4: set wins (ptr=2, scan reaches 0)
    bus.reqValid = 3'b001;
    setReq(0, 5'd4, 32'h44);
    bus.reserveValid = 1'b1;
    bus.reserveAddr = 5'd4;
    bus.rAddr2 = 5'd4;
    #1;
    check("sim4_grant", 64'(bus.reqReady), 64'(3'b001));
    check("sim4_reserveReady", 64'(bus.reserveReady), 64'd1);
    tick();
    check("sim4_busyCount", 64'(bus.busyCount), 64'd1);
    check("sim4_hazard2", 64'(bus.hazard2), 64'd1);
    // Reserve r6 while clearing busy r4: net zero
    bus.reserveAddr = 5'd6;
    bus.rAddr1 = 5'd6;
    #1;
    check("sim6_grant", 64'(bus.reqReady), 64'(3'b001));
    tick();
    check("sim6_busyCount", 64'(bus.busyCount), 64'd1);
    check("sim6_hazard1", 64'(bus.hazard1), 64'd1);
    check("sim6_hazard2_rfterm", 64'(bus.hazard2), 64'd1);
    bus.reqValid = '0;
    bus.reserveValid = 1'b0;
    tick();
    check("sim6_hazard2_clear", 64'(bus.hazard2), 64'd0);

    // enable=0 freezes; ptr is 1 from the last grant to requester 0
    enable = 1'b0;
    bus.reqValid = 3'b111;
    setReq(0, 5'd1, 32'h101);
    setReq(1, 5'd2, 32'h102);
    setReq(2, 5'd3, 32'h103);
    bus.reserveValid = 1'b1;
    bus.reserveAddr = 5'd7;
    #1;
    check("dis_grant", 64'(bus.reqReady), 64'd0);
    check("dis_reserveReady", 64'(bus.reserveReady), 64'd0);
    tick();
    check("dis_rfWrite", 64'(bus.rfWrite), 64'd0);
    check("dis_busyCount", 64'(bus.busyCount), 64'd1);
    tick();
    enable = 1'b1;
    #1;
    check("reen_grant", 64'(bus.reqReady), 64'(3'b010));
    tick();
    check("reen_rfWAddr", 64'(bus.rfWAddr), 64'd2);
    check("reen_busyCount", 64'(bus.busyCount), 64'd2);
    bus.reserveAddr = 5'd8;
    #1;
    check("reen_grant2", 64'(bus.reqReady), 64'(3'b100));
    tick();
    check("pre_rst_rfWrite", 64'(bus.rfWrite), 64'd1);
    check("pre_rst_busyCount", 64'(bus.busyCount), 64'd3);

    // Reset mid-operation with requests still active
    reset = 1'b0;
    tick();
    check("mid_rst_rfWrite", 64'(bus.rfWrite), 64'd0);
    check("mid_rst_busyCount", 64'(bus.busyCount), 64'd0);
    reset = 1'b1;
    bus.reqValid = '0;
    bus.reserveValid = 1'b0;
    tick();
    check("mid_rst_hazard1", 64'(bus.hazard1), 64'd0);
    bus.reqValid = 3'b111;
    #1;
    check("mid_rst_ptr", 64'(bus.reqReady), 64'(3'b001));
    bus.reqValid = '0;

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the single register-file write port between ReqCount writeback requesters, e.g. ALU, load unit and multiply/divide unit.
- Arbitration is round-robin over a valid/ready handshake. The winning request is registered onto the register file's write/wAddr/wData inputs.
- A per-register busy scoreboard is reserved at issue and cleared at writeback. It drives read-hazard flags for the two read ports.

Parameters:
BitWidth, 32, width of register data
RegCount, 32, number of registers; AW = minimum width to encode RegCount (at least 1)
ReqCount, 3, number of writeback requesters (at least 2)

Ports:
clock  input  1  single clock; all state changes on the rising edge
reset  input  1  synchronous, active-low; sampled on the rising edge of clock
enable  input  1  0 freezes arbitration and scoreboard updates
reqValid  input  ReqCount  bit i: requester i has a write pending
reqAddr  input  ReqCount*AW  slice i: destination register of requester i
reqData  input  ReqCount*BitWidth  slice i: write data of requester i
reqReady  output  ReqCount  one-hot grant (combinational)
reserveValid  input  1  issue stage marks reserveAddr as pending
reserveAddr  input  AW  register to reserve
reserveReady  output  1  reservation accepted (combinational)
rAddr1  input  AW  read-port-1 address, mirrored from the register file
rAddr2  input  AW  read-port-2 address, mirrored from the register file
hazard1  output  1  rAddr1 data is stale
hazard2  output  1  rAddr2 data is stale
rfWrite  output  1  to register-file write (registered)
rfWAddr  output  AW  to register-file wAddr (registered)
rfWData  output  BitWidth  to register-file wData (registered)
busyCount  output  AW+1  number of busy registers (registered)

Behaviour:
- Reset (reset=0 at a rising edge):
  - busy[] all 0, round-robin pointer ptr=0.
  - rfWrite=0, rfWAddr=0, rfWData=0, busyCount=0.
  - Any in-flight grant or reservation in that cycle is discarded.
  - Reset overrides enable.
- Arbitration (combinational, enable=1):
  - Scan indices ptr, ptr+1, … mod ReqCount.
  - The first i with reqValid[i]=1 gets reqReady[i]=1; all other reqReady bits are 0.
  - No valid request: reqReady=0.
- Handshake:
  - A transfer occurs when reqValid[i] & reqReady[i].
  - Requesters hold valid/addr/data stable until ready.
  - At most one transfer per cycle; 100% throughput.
- Transfer at cycle t; at the edge ending t:
  - rfWrite<=1, rfWAddr<=reqAddr[i], rfWData<=reqData[i].
  - ptr<=(i+1) mod ReqCount.
  - busy[reqAddr[i]]<=0.
- No transfer at cycle t:
  - rfWrite<=0; rfWAddr/rfWData hold their values.
  - ptr holds.
- Latency: one cycle from handshake to rfWrite. The register file commits at the edge ending t+1.
- Reservation:
  - reserveReady = enable & ~busy[reserveAddr].
  - Accept (reserveValid & reserveReady): busy[reserveAddr]<=1.
  - A reservation request while reserveReady=0 is ignored; the issuer stalls.
- Same-cycle reservation and transfer to the same register:
  - Only possible when that register is not busy (plain writeback of a non-busy register).
  - Set wins: busy ends at 1.
- Writeback to a register that is not busy is legal; busy stays 0 and busyCount is unchanged.
- busyCount:
  - +1 per accepted reservation that sets a 0 bit.
  - −1 per transfer that clears a 1 bit.
  - Net 0 when both happen in one cycle.
  - Never wraps: ranges 0..RegCount.
- Hazard (combinational, independent of enable):
  - hazardN = busy[rAddrN] | (rfWrite & rfWAddr==rAddrN).
  - The rfWrite term covers the cycle before the register file commits.
- enable=0:
  - reqReady=0 and reserveReady=0.
  - busy[], ptr and busyCount hold.
  - rfWrite<=0 at the next edge; rfWAddr/rfWData hold.
- All registers are written on posedge clock only; there are no asynchronous paths.

Test Plan:
- Reset: hold reset=0 with all inputs active for 2 cycles -> rfWrite=0, busyCount=0, reqReady=0, hazard1=0 when rAddr1=5 (busy[5]=0, rfWrite=0).
- Round-robin: reqValid=3'b111 for 6 cycles, addrs 1/2/3 -> grants 0,1,2,0,1,2. rfWAddr sequence 1,2,3,1,2,3 appears one cycle after each grant, with rfWrite=1 continuously.
- Single requester:
  - reqValid=3'b100, addr 7, data 0xDEADBEEF -> reqReady=3'b100 the same cycle; next cycle rfWrite=1, rfWAddr=7, rfWData=0xDEADBEEF.
  - Then reqValid=0 -> rfWrite=0.
- Scoreboard:
  - Reserve r9 -> busyCount=1; rAddr1=9 gives hazard1=1; a second reserve of r9 sees reserveReady=0.
  - Requester 1 writes r9 -> after the handshake edge hazard1 stays 1 via the rfWrite term.
  - One cycle later hazard1=0 and busyCount=0.
- Simultaneous: in one cycle reserve r4 and transfer to r4 (not busy) -> busy[4]=1, busyCount=1. In another cycle reserve r6 while clearing busy r4 -> busyCount unchanged.
- enable and reset mid-operation:
  - enable=0 with reqValid=3'b111 -> reqReady=0, rfWrite=0 after one edge, ptr unchanged on re-enable.
  - reset=0 with rfWrite=1 and busyCount=3 -> next cycle rfWrite=0 and busyCount=0.
